// File: rtl/vram_port_a_arbiter.sv
// ---------------------------------------------------------------------------
// vram_port_a_arbiter
//
// Owns port A of the dual-port VRAM. Two requesters (0 = CPU/bus,
// 1 = blitter/aux) share the port with round-robin arbitration, and a
// built-in clear sequencer can fill the whole memory with one word.
//
// Handshake: a requester raises req_x with rw/addr/wdata stable and holds
// them until ack_x. A transfer happens on every rising clock edge where
// req_x and ack_x are both high; ack_x is combinational and may be high
// for many consecutive cycles (one access per cycle). Reads return with
// rvalid_x high for exactly one cycle, two cycles after the handshake.
//
// Ports:
//   clock, reset              pixel clock / async active-high reset
//   req_x, rw_x, addr_x,
//   wdata_x                   requester x command (rw 1 = write)
//   ack_x                     requester x handshake accepted this cycle
//   rdata_x, rvalid_x         requester x read return
//   clear_start, clear_value  start a full clear with the given fill word
//   clear_busy, clear_done    clear in progress / completion pulse
//   vram_enable, vram_rw,
//   vram_addr, vram_wdata     registered RAM port A command
//   vram_rdata                RAM port A read data
//   state_dbg                 current FSM state (0 = IDLE, 1 = CLEAR)
// ---------------------------------------------------------------------------
module vram_port_a_arbiter #(
  parameter int MEMORY_DEPTH = 19200,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic                  rw_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  ack_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  rvalid_0,
  input  logic                  req_1,
  input  logic                  rw_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  ack_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rvalid_1,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  vram_enable,
  output logic                  vram_rw,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0] vram_wdata,
  input  logic [DATA_WIDTH-1:0] vram_rdata,
  output logic                  state_dbg
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);

  state_t                  state, state_next;
  logic                    last_grant;   // 1: requester 1 was served last
  logic [ADDR_WIDTH-1:0]   clear_cnt;    // address currently on the RAM during CLEAR
  logic [DATA_WIDTH-1:0]   clear_latch;
  logic [1:0]              rd_pend;      // owner of the read command now on the RAM
  logic                    sel_0, sel_1, arb_open;

  assign state_dbg = state;

  // Read data is a straight pass-through; rvalid_x qualifies it.
  assign rdata_0 = vram_rdata;
  assign rdata_1 = vram_rdata;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_start) state_next = CLEAR;
      CLEAR:   if (clear_cnt == LAST_ADDR) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: round-robin select, gated off during reset, CLEAR and a
  // clear_start cycle (clear wins over a simultaneous request).
  always_comb begin
    sel_0    = req_0 & (~req_1 | last_grant);
    sel_1    = req_1 & (~req_0 | ~last_grant);
    arb_open = (state == IDLE) & ~clear_start & ~reset;
    ack_0    = sel_0 & arb_open;
    ack_1    = sel_1 & arb_open;
  end

  // Datapath: RAM command register, clear counter, read-return pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vram_enable <= 1'b0;
      vram_rw     <= 1'b0;
      vram_addr   <= '0;
      vram_wdata  <= '0;
      rvalid_0    <= 1'b0;
      rvalid_1    <= 1'b0;
      rd_pend     <= 2'b00;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      clear_cnt   <= '0;
      clear_latch <= '0;
      last_grant  <= 1'b1;
    end else begin
      vram_enable <= 1'b0;
      clear_done  <= 1'b0;
      rd_pend     <= 2'b00;
      // Second pipeline stage: the RAM returns data the cycle after the command.
      rvalid_0    <= rd_pend[0];
      rvalid_1    <= rd_pend[1];
      case (state)
        IDLE: begin
          if (clear_start) begin
            vram_enable <= 1'b1;
            vram_rw     <= 1'b1;
            vram_addr   <= '0;
            vram_wdata  <= clear_value;
            clear_latch <= clear_value;
            clear_cnt   <= '0;
            clear_busy  <= 1'b1;
          end else if (ack_0) begin
            vram_enable <= 1'b1;
            vram_rw     <= rw_0;
            vram_addr   <= addr_0;
            vram_wdata  <= wdata_0;
            last_grant  <= 1'b0;
            rd_pend     <= {1'b0, ~rw_0};
          end else if (ack_1) begin
            vram_enable <= 1'b1;
            vram_rw     <= rw_1;
            vram_addr   <= addr_1;
            vram_wdata  <= wdata_1;
            last_grant  <= 1'b1;
            rd_pend     <= {~rw_1, 1'b0};
          end
        end
        CLEAR: begin
          if (clear_cnt == LAST_ADDR) begin
            // Final address already issued: retire the sequence.
            clear_cnt  <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clear_cnt   <= clear_cnt + 1'b1;
            vram_enable <= 1'b1;
            vram_rw     <= 1'b1;
            vram_addr   <= clear_cnt + 1'b1;
            vram_wdata  <= clear_latch;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vram_port_a_arbiter.md
Name: vram_port_a_arbiter

Overview:
- Owns VRAM port A of the dual-port sync RAM. Port B stays dedicated to the VGA scan-out path.
- Shares port A between two requesters (req 0 = CPU/bus, req 1 = blitter/aux) with round-robin arbitration.
- Contains a built-in clear sequencer that fills the whole VRAM with one value.
- Drives the RAM's clock_a domain directly; all logic runs on the pixel clock.

Parameters:
- MEMORY_DEPTH, 19200, number of 16-bit VRAM words; clear covers addresses 0..MEMORY_DEPTH-1.
- ADDR_WIDTH, 16, address width of requesters and RAM.
- DATA_WIDTH, 16, data word width.

Ports:
- clock  in  1  system clock (same clock as VRAM port A).
- reset  in  1  asynchronous, active-high reset.
- req_0  in  1  requester 0 access request; hold until ack_0.
- rw_0  in  1  requester 0: 1 = write, 0 = read.
- addr_0  in  ADDR_WIDTH  requester 0 address.
- wdata_0  in  DATA_WIDTH  requester 0 write data.
- ack_0  out  1  requester 0 handshake accepted this cycle (combinational).
- rdata_0  out  DATA_WIDTH  requester 0 read data; valid when rvalid_0.
- rvalid_0  out  1  requester 0 read data valid pulse.
- req_1, rw_1, addr_1, wdata_1, ack_1, rdata_1, rvalid_1: same as requester 0, for requester 1.
- clear_start  in  1  single-cycle pulse; start a full-VRAM clear.
- clear_value  in  DATA_WIDTH  fill word; sampled only on an accepted clear_start.
- clear_busy  out  1  clear sequence in progress.
- clear_done  out  1  one-cycle pulse when the clear completes.
- vram_enable  out  1  to RAM enable_a.
- vram_rw  out  1  to RAM rw_a (1 = write).
- vram_addr  out  ADDR_WIDTH  to RAM address_a.
- vram_wdata  out  DATA_WIDTH  to RAM data_in_a.
- vram_rdata  in  DATA_WIDTH  from RAM data_out_a.

Behaviour:

Reset values:
- vram_enable, vram_rw, vram_addr, vram_wdata: 0.
- rvalid_0/1, clear_busy, clear_done: 0.
- State: IDLE. last_grant = 1, so requester 0 wins the first tie.
- clear counter: 0.
- ack_0/1 forced to 0 while reset is high.

States: IDLE, CLEAR.

IDLE:
- ack_x = req_x AND selected. Selection:
  - Only one requester high: that requester is selected.
  - Both high: the requester that is not last_grant is selected.
- A handshake occurs on a clock edge where req_x and ack_x are both high. At that edge:
  - vram_enable <= 1.
  - vram_rw, vram_addr, vram_wdata <= the winning requester's rw/addr/wdata.
  - last_grant <= x.
- No handshake: vram_enable <= 0. vram_addr and vram_wdata hold their values.
- Throughput is one access per cycle. A requester holding req high after ack issues its next command back-to-back.

Read latency:
- Handshake in cycle N → RAM command in cycle N+1 → rvalid_x = 1 for exactly cycle N+2.
- rdata_x = vram_rdata, passed through. Its value is meaningful only when rvalid_x is high.
- A pending-read shift register records the owner of each outstanding read.
- Writes produce no rvalid.

clear_start in IDLE:
- Enter CLEAR and latch clear_value.
- ack_0 and ack_1 are 0 in that cycle; clear has priority over a simultaneous req.
- clear_busy goes high the next cycle.

CLEAR:
- Each cycle: vram_enable = 1, vram_rw = 1, vram_wdata = latched value, vram_addr = counter. The counter increments.
- Addresses issued run 0..MEMORY_DEPTH-1 (19200 cycles at default).
- ack_0/1 are held at 0 for the whole state.
- Reads issued before the clear still return their rvalid on schedule.
- After address MEMORY_DEPTH-1 is issued, the next cycle:
  - vram_enable = 0, clear_busy = 0, clear_done = 1 for one cycle.
  - Counter returns to 0; state returns to IDLE.
- Arbitration resumes that same cycle. last_grant is unchanged by the clear.

Other rules:
- clear_start while clear_busy is high is ignored; clear_value is not re-latched.
- Reset mid-clear: abort immediately and apply all reset values. A later clear restarts at address 0.
- Reset with reads outstanding: pending reads are discarded and no rvalid is produced.
- Address arithmetic: the counter is ADDR_WIDTH wide and compared against MEMORY_DEPTH-1. The counter never exceeds MEMORY_DEPTH-1.

Test Plan:
1. req_0=1, rw_0=1, addr_0=0x0010, wdata_0=0xABCD for one cycle → ack_0=1 that cycle; next cycle vram_enable=1, vram_rw=1, vram_addr=0x0010, vram_wdata=0xABCD; rvalid_0 never asserts.
2. Write 0x1234 to 0x0005, then read 0x0005 via req_1 → ack_1 in cycle N; rvalid_1=1 only in cycle N+2 with rdata_1=0x1234; rvalid_0 stays 0.
3. req_0 and req_1 both held high with reads to 0x0001/0x0002 after reset → acks alternate 0,1,0,1; vram_addr alternates 0x0001,0x0002; each rvalid arrives 2 cycles after its ack.
4. MEMORY_DEPTH=8; clear_start with clear_value=0x00FF while req_0 is high → ack_0=0; writes to addresses 0..7 on 8 consecutive cycles; clear_busy high for those 8 cycles; clear_done pulses once; ack_0 asserts in the clear_done cycle; read-back of all 8 addresses returns 0x00FF.
5. MEMORY_DEPTH=8; second clear_start during CLEAR with a different value → ignored; still exactly 8 writes of the original value; a single clear_done.
6. MEMORY_DEPTH=8; assert reset after address 3 is written → all outputs go to 0 asynchronously; a new clear_start issues address 0 first and completes 8 writes.
